// File: rtl/code_patch_unit_if.sv
// rtl/code_patch_unit_if.sv - fetch-side bus between instruction fetch/code ROM and code_patch_unit
//   master : drives si_read_i, si_addr_i, rom_data_i; receives rd_valid_o, rd_data_o, nopg_o, hit_idx_o
//   slave  : the patch unit (mirror of master)
interface code_patch_unit_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 22,
   parameter int IDX_W  = 3
);
   logic              si_read_i;
   logic [ADDR_W-1:0] si_addr_i;
   logic [DATA_W-1:0] rom_data_i;
   logic              rd_valid_o;
   logic [DATA_W-1:0] rd_data_o;
   logic              nopg_o;
   logic [IDX_W-1:0]  hit_idx_o;

   modport master (
      output si_read_i, si_addr_i, rom_data_i,
      input  rd_valid_o, rd_data_o, nopg_o, hit_idx_o
   );

   modport slave (
      input  si_read_i, si_addr_i, rom_data_i,
      output rd_valid_o, rd_data_o, nopg_o, hit_idx_o
   );
endinterface

// File: rtl/code_patch_unit.sv
// rtl/code_patch_unit.sv - multi-entry pipelined code-patch unit between fetch port and code ROM
//   clk_i, rst_i       : clock, synchronous active-high reset
//   cfg_pat_gen_i      : global patch enable (sampled in stage 1)
//   cfg_we_i/idx/addr/data/valid : entry write port
//   cfg_clr_i          : invalidate all entries (wins over cfg_we_i)
//   fetch              : fetch/ROM bus (code_patch_unit_if.slave)
//   hit_cnt_o          : saturating patch-hit counter, present only with CODE_PATCH_HIT_CNT_EN
module code_patch_unit #(
   parameter int NUM_PATCH = 8,
   parameter int ADDR_W    = 13,
   parameter int DATA_W    = 22,
   parameter int IDX_W     = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cfg_pat_gen_i,
   input  logic              cfg_we_i,
   input  logic [IDX_W-1:0]  cfg_idx_i,
   input  logic [ADDR_W-1:0] cfg_addr_i,
   input  logic [DATA_W-1:0] cfg_data_i,
   input  logic              cfg_valid_i,
   input  logic              cfg_clr_i,
   code_patch_unit_if.slave  fetch
`ifdef CODE_PATCH_HIT_CNT_EN
   ,
   output logic [15:0]       hit_cnt_o
`endif
);

   logic [NUM_PATCH-1:0] ent_valid;
   logic [ADDR_W-1:0]    ent_addr [NUM_PATCH];
   logic [DATA_W-1:0]    ent_data [NUM_PATCH];

   logic                 cmp_hit;
   logic [IDX_W-1:0]     cmp_idx;
   logic [DATA_W-1:0]    cmp_data;

   logic                 s1_valid;
   logic                 s1_hit;
   logic [IDX_W-1:0]     s1_idx;
   logic [DATA_W-1:0]    s1_data;

   logic                 rd_valid_q;
   logic [DATA_W-1:0]    rd_data_q;
   logic                 nopg_q;
   logic [IDX_W-1:0]     hit_idx_q;

   // Valid bits: clear beats write. Indices >= NUM_PATCH match no entry and are dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i || cfg_clr_i) begin
         ent_valid <= '0;
      end else if (cfg_we_i) begin
         for (int i = 0; i < NUM_PATCH; i++) begin
            if (cfg_idx_i == IDX_W'(i)) ent_valid[i] <= cfg_valid_i;
         end
      end
   end

   // Address/data payload is only meaningful while valid, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (cfg_we_i) begin
         for (int i = 0; i < NUM_PATCH; i++) begin
            if (cfg_idx_i == IDX_W'(i)) begin
               ent_addr[i] <= cfg_addr_i;
               ent_data[i] <= cfg_data_i;
            end
         end
      end
   end

   // Scan from the top down so the lowest matching index is the last one assigned.
   always_comb begin
      cmp_hit  = 1'b0;
      cmp_idx  = '0;
      cmp_data = '0;
      for (int i = NUM_PATCH - 1; i >= 0; i--) begin
         if (cfg_pat_gen_i && ent_valid[i] && (ent_addr[i] == fetch.si_addr_i)) begin
            cmp_hit  = 1'b1;
            cmp_idx  = IDX_W'(i);
            cmp_data = ent_data[i];
         end
      end
   end

   // Stage 1: capture the match result against the pre-write table contents.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_hit   <= 1'b0;
         s1_idx   <= '0;
         s1_data  <= '0;
      end else begin
         s1_valid <= fetch.si_read_i;
         if (fetch.si_read_i) begin
            s1_hit  <= cmp_hit;
            s1_idx  <= cmp_idx;
            s1_data <= cmp_data;
         end
      end
   end

   // Stage 2: merge with the ROM word, which arrives the cycle after the request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         nopg_q     <= 1'b1;
         hit_idx_q  <= '0;
      end else begin
         rd_valid_q <= s1_valid;
         if (s1_valid) begin
            rd_data_q <= s1_hit ? s1_data : fetch.rom_data_i;
            nopg_q    <= !s1_hit;
            hit_idx_q <= s1_hit ? s1_idx : '0;
         end
      end
   end

   assign fetch.rd_valid_o = rd_valid_q;
   assign fetch.rd_data_o  = rd_data_q;
   assign fetch.nopg_o     = nopg_q;
   assign fetch.hit_idx_o  = hit_idx_q;

`ifdef CODE_PATCH_HIT_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i || cfg_clr_i) begin
         hit_cnt_o <= '0;
      end else if (s1_valid && s1_hit && (hit_cnt_o != 16'hFFFF)) begin
         hit_cnt_o <= hit_cnt_o + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_code_patch_unit.sv
// tb/tb_code_patch_unit.sv - self-checking bench for code_patch_unit (directed table, random vs model)
module tb_code_patch_unit;
   localparam int NUM_PATCH = 8;
   localparam int ADDR_W    = 13;
   localparam int DATA_W    = 22;
   localparam int IDX_W     = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              pg;
   logic              we;
   logic [IDX_W-1:0]  cidx;
   logic [ADDR_W-1:0] caddr;
   logic [DATA_W-1:0] cdata;
   logic              cval;
   logic              clr;
`ifdef CODE_PATCH_HIT_CNT_EN
   logic [15:0]       hit_cnt;
`endif

   code_patch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) fif ();

   code_patch_unit #(
      .NUM_PATCH(NUM_PATCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cfg_pat_gen_i(pg),
      .cfg_we_i     (we),
      .cfg_idx_i    (cidx),
      .cfg_addr_i   (caddr),
      .cfg_data_i   (cdata),
      .cfg_valid_i  (cval),
      .cfg_clr_i    (clr),
      .fetch        (fif)
`ifdef CODE_PATCH_HIT_CNT_EN
      ,
      .hit_cnt_o    (hit_cnt)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clk_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; pg = 1'b1; we = 1'b0; cidx = '0; caddr = '0; cdata = '0;
      cval = 1'b0; clr = 1'b0;
      fif.si_read_i = 1'b0; fif.si_addr_i = '0; fif.rom_data_i = '0;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic              rst, pg, we;
      logic [IDX_W-1:0]  idx;
      logic [ADDR_W-1:0] caddr;
      logic [DATA_W-1:0] cdata;
      logic              cval, clr, rd;
      logic [ADDR_W-1:0] saddr;
      logic [DATA_W-1:0] rom;
      logic              e_v;
      logic [DATA_W-1:0] e_d;
      logic              e_n;
      logic [IDX_W-1:0]  e_i;
      logic [15:0]       e_c;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int r, input int p, input int w, input int ix, input int ca, input int cd,
                      input int cv, input int cl, input int rd, input int sa, input int rom,
                      input int ev, input int ed, input int en, input int ei, input int ec);
      vec_t v;
      v.rst = r[0]; v.pg = p[0]; v.we = w[0]; v.idx = IDX_W'(ix); v.caddr = ADDR_W'(ca);
      v.cdata = DATA_W'(cd); v.cval = cv[0]; v.clr = cl[0]; v.rd = rd[0]; v.saddr = ADDR_W'(sa);
      v.rom = DATA_W'(rom); v.e_v = ev[0]; v.e_d = DATA_W'(ed); v.e_n = en[0]; v.e_i = IDX_W'(ei);
      v.e_c = 16'(ec);
      tbl.push_back(v);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic              hit;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } pend_t;

   logic              m_valid [NUM_PATCH];
   logic [ADDR_W-1:0] m_addr  [NUM_PATCH];
   logic [DATA_W-1:0] m_data  [NUM_PATCH];
   pend_t             pend_q[$];
   logic              x_v;
   logic [DATA_W-1:0] x_d;
   logic              x_n;
   logic [IDX_W-1:0]  x_i;
   int                x_c;

   // Called with the inputs that the coming clock edge will sample.
   task automatic model_edge();
      pend_t p;
      pend_t np;
      if (rst) begin
         for (int k = 0; k < NUM_PATCH; k++) m_valid[k] = 1'b0;
         pend_q.delete();
         x_v = 1'b0; x_d = '0; x_n = 1'b1; x_i = '0; x_c = 0;
         return;
      end
      if (pend_q.size() > 0) begin
         p   = pend_q.pop_front();
         x_v = 1'b1;
         x_d = p.hit ? p.data : fif.rom_data_i;
         x_n = !p.hit;
         x_i = p.hit ? p.idx : '0;
         if (p.hit && x_c < 65535) x_c++;
      end else begin
         x_v = 1'b0;
      end
      if (fif.si_read_i) begin
         np.hit = 1'b0; np.idx = '0; np.data = '0;
         for (int k = 0; k < NUM_PATCH; k++) begin
            if (!np.hit && pg && m_valid[k] && m_addr[k] == fif.si_addr_i) begin
               np.hit = 1'b1; np.idx = IDX_W'(k); np.data = m_data[k];
            end
         end
         pend_q.push_back(np);
      end
      if (clr) begin
         for (int k = 0; k < NUM_PATCH; k++) m_valid[k] = 1'b0;
         x_c = 0;
      end else if (we && int'(cidx) < NUM_PATCH) begin
         m_valid[cidx] = cval;
         m_addr[cidx]  = caddr;
         m_data[cidx]  = cdata;
      end
   endtask

   initial begin
      idle_inputs();

      //   rst pg we idx caddr   cdata     cv cl rd saddr  rom        ev e_d       en ei ec
      add(1, 0, 0, 0, 0,      0,        0, 0, 0, 0,     0,         0, 0,        1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h010, 0,         0, 0,        1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     'h0ABCD,   1, 'h0ABCD,  1, 0, 0);
      add(0, 1, 1, 3, 'h010,  'h3FFFFF, 1, 0, 0, 0,     0,         0, 'h0ABCD,  1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h010, 0,         0, 'h0ABCD,  1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     'h01111,   1, 'h3FFFFF, 0, 3, 1);
      add(0, 0, 0, 0, 0,      0,        0, 0, 1, 'h010, 0,         0, 'h3FFFFF, 0, 3, 1);
      add(0, 0, 0, 0, 0,      0,        0, 0, 0, 0,     'h02222,   1, 'h02222,  1, 0, 1);
      add(0, 1, 1, 2, 'h020,  'h22222,  1, 0, 0, 0,     0,         0, 'h02222,  1, 0, 1);
      add(0, 1, 1, 5, 'h020,  'h55555,  1, 0, 0, 0,     0,         0, 'h02222,  1, 0, 1);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h020, 0,         0, 'h02222,  1, 0, 1);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h021, 'h0AAAA,   1, 'h22222,  0, 2, 2);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h020, 'h0BBBB,   1, 'h0BBBB,  1, 0, 2);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     'h0CCCC,   1, 'h22222,  0, 2, 3);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     0,         0, 'h22222,  0, 2, 3);
      add(0, 1, 1, 0, 'h030,  'h30303,  1, 0, 1, 'h030, 0,         0, 'h22222,  0, 2, 3);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h030, 'h0DDDD,   1, 'h0DDDD,  1, 0, 3);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     'h0EEEE,   1, 'h30303,  0, 0, 4);
      add(0, 1, 1, 1, 'h040,  'h40404,  1, 1, 0, 0,     0,         0, 'h30303,  0, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h040, 0,         0, 'h30303,  0, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h030, 'h0F0F0,   1, 'h0F0F0,  1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h020, 'h01234,   1, 'h01234,  1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     'h05678,   1, 'h05678,  1, 0, 0);
      add(0, 1, 1, 4, 'h050,  'h12345,  1, 0, 0, 0,     0,         0, 'h05678,  1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h050, 0,         0, 'h05678,  1, 0, 0);
      add(1, 1, 0, 0, 0,      0,        0, 0, 0, 0,     'h09999,   0, 0,        1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     0,         0, 0,        1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h050, 0,         0, 0,        1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     'h07777,   1, 'h07777,  1, 0, 0);
      add(0, 1, 1, 6, 'h060,  'h06666,  1, 0, 0, 0,     0,         0, 'h07777,  1, 0, 0);
      add(0, 1, 1, 6, 'h060,  'h06666,  0, 0, 0, 0,     0,         0, 'h07777,  1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 1, 'h060, 0,         0, 'h07777,  1, 0, 0);
      add(0, 1, 0, 0, 0,      0,        0, 0, 0, 0,     'h0AAAA,   1, 'h0AAAA,  1, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; pg = tbl[i].pg; we = tbl[i].we; cidx = tbl[i].idx;
         caddr = tbl[i].caddr; cdata = tbl[i].cdata; cval = tbl[i].cval; clr = tbl[i].clr;
         fif.si_read_i = tbl[i].rd; fif.si_addr_i = tbl[i].saddr; fif.rom_data_i = tbl[i].rom;
         clk_edge();
         chk($sformatf("row%0d rd_valid", i), 32'(fif.rd_valid_o), 32'(tbl[i].e_v));
         chk($sformatf("row%0d rd_data", i),  32'(fif.rd_data_o),  32'(tbl[i].e_d));
         chk($sformatf("row%0d nopg", i),     32'(fif.nopg_o),     32'(tbl[i].e_n));
         chk($sformatf("row%0d hit_idx", i),  32'(fif.hit_idx_o),  32'(tbl[i].e_i));
`ifdef CODE_PATCH_HIT_CNT_EN
         chk($sformatf("row%0d hit_cnt", i),  32'(hit_cnt),        32'(tbl[i].e_c));
`endif
      end

      // Hand sequence: patched read killed by reset the next cycle must never surface.
      idle_inputs();
      we = 1'b1; cidx = 3'd7; caddr = 13'h0777; cdata = 22'h177777; cval = 1'b1;
      clk_edge();
      idle_inputs();
      fif.si_read_i = 1'b1; fif.si_addr_i = 13'h0777;
      clk_edge();
      idle_inputs();
      rst = 1'b1; fif.rom_data_i = 22'h0BEEF;
      clk_edge();
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("rstflight c%0d rd_valid", c), 32'(fif.rd_valid_o), 32'd0);
         chk($sformatf("rstflight c%0d rd_data", c),  32'(fif.rd_data_o),  32'd0);
         chk($sformatf("rstflight c%0d nopg", c),     32'(fif.nopg_o),     32'd1);
         clk_edge();
      end

      // Random phase against the reference model.
      idle_inputs();
      rst = 1'b1;
      model_edge();
      clk_edge();
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 199) == 0);
         pg    = ($urandom_range(0, 7) != 0);
         we    = ($urandom_range(0, 3) == 0);
         cidx  = IDX_W'($urandom);
         caddr = ADDR_W'($urandom_range(0, 15));
         cdata = DATA_W'($urandom);
         cval  = ($urandom_range(0, 4) != 0);
         clr   = ($urandom_range(0, 63) == 0);
         fif.si_read_i  = ($urandom_range(0, 3) != 0);
         fif.si_addr_i  = ADDR_W'($urandom_range(0, 15));
         fif.rom_data_i = DATA_W'($urandom);
         model_edge();
         clk_edge();
         chk($sformatf("rnd%0d rd_valid", n), 32'(fif.rd_valid_o), 32'(x_v));
         chk($sformatf("rnd%0d rd_data", n),  32'(fif.rd_data_o),  32'(x_d));
         chk($sformatf("rnd%0d nopg", n),     32'(fif.nopg_o),     32'(x_n));
         chk($sformatf("rnd%0d hit_idx", n),  32'(fif.hit_idx_o),  32'(x_i));
`ifdef CODE_PATCH_HIT_CNT_EN
         chk($sformatf("rnd%0d hit_cnt", n),  32'(hit_cnt),        32'(x_c));
`endif
      end

`ifdef CODE_PATCH_HIT_CNT_EN
      // Hand sequence: drive the counter up to and into saturation.
      idle_inputs();
      clr = 1'b1;
      clk_edge();
      idle_inputs();
      we = 1'b1; cidx = 3'd0; caddr = 13'h0100; cdata = 22'h000100; cval = 1'b1;
      clk_edge();
      idle_inputs();
      fif.si_read_i = 1'b1; fif.si_addr_i = 13'h0100;
      for (int n = 0; n < 65534; n++) clk_edge();
      idle_inputs();
      clk_edge();
      clk_edge();
      chk("sat near", 32'(hit_cnt), 32'h0000FFFE);
      fif.si_read_i = 1'b1; fif.si_addr_i = 13'h0100;
      for (int n = 0; n < 3; n++) clk_edge();
      idle_inputs();
      clk_edge();
      clk_edge();
      chk("sat hold", 32'(hit_cnt), 32'h0000FFFF);
      clr = 1'b1;
      clk_edge();
      idle_inputs();
      chk("sat clr", 32'(hit_cnt), 32'h00000000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
